// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and default widths for the register-bank arbiter.
// Optional grant locking is enabled with the ARB_LOCK_EN macro.
`ifndef REG_BANK_ARBITER_PKG_SV
`define REG_BANK_ARBITER_PKG_SV
package reg_bank_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_AW    = 3;

  // Index width for a requester pointer; never zero even for a single lane.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`endif

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first unmasked request at or above ptr,
// wrapping modulo NREQ, plus the pointer that follows the winner.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win_onehot,
  output logic [PW-1:0]   win_idx,
  output logic [PW-1:0]   next_ptr,
  output logic            any
);

  logic [NREQ-1:0] masked;
  logic [PW-1:0]   cand;

  always_comb begin
    masked     = req & ~mask;
    win_onehot = '0;
    win_idx    = '0;
    next_ptr   = ptr;
    any        = 1'b0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!any && masked[cand]) begin
        any              = 1'b1;
        win_idx          = cand;
        win_onehot[cand] = 1'b1;
        next_ptr         = PW'((int'(cand) + 1) % NREQ);
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin sharing of one external single-port register bank between
// NREQ requesters; optional grant locking when ARB_LOCK_EN is defined.
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rvalid,
  output logic [WIDTH-1:0]      rdata,
  output logic                  bank_load,
  output logic [AW-1:0]         bank_addr,
  output logic [WIDTH-1:0]      bank_in,
  input  logic [WIDTH-1:0]      bank_out
);

  localparam int PW = ptr_width(NREQ);

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [NREQ-1:0] arb_onehot;
  logic [PW-1:0]   arb_idx;
  logic [PW-1:0]   arb_next;
  logic            arb_any;
  logic            hold;

  // The current grantee is masked so it cannot win two arbitrations in a row.
  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req        (req),
    .mask       (gnt),
    .ptr        (ptr),
    .win_onehot (arb_onehot),
    .win_idx    (arb_idx),
    .next_ptr   (arb_next),
    .any        (arb_any)
  );

`ifdef ARB_LOCK_EN
  assign hold = (state == GRANT) && lock[win] && req[win];
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= '0;
      win    <= '0;
      ptr    <= '0;
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= '0;
      if (state == GRANT && !we[win]) begin
        rdata  <= bank_out;
        rvalid <= gnt;
      end
      if (hold) begin
        // Locked grantee keeps the bank; gnt, win and the pointer stay put.
        state <= GRANT;
      end else if (arb_any) begin
        state <= GRANT;
        gnt   <= arb_onehot;
        win   <= arb_idx;
        ptr   <= arb_next;
      end else begin
        state <= IDLE;
        gnt   <= '0;
      end
    end
  end

  always_comb begin
    bank_load = 1'b0;
    bank_addr = '0;
    bank_in   = '0;
    if (state == GRANT) begin
      bank_addr = addr[int'(win)*AW +: AW];
      bank_in   = wdata[int'(win)*WIDTH +: WIDTH];
      bank_load = we[win] & ~reset;
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter with a behavioural register bank and a read scoreboard.
module tb_reg_bank_arbiter;

  localparam int NREQ  = 2;
  localparam int WIDTH = 16;
  localparam int AW    = 3;
  localparam int W     = NREQ + WIDTH;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       we;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*WIDTH-1:0] wdata;
`ifdef ARB_LOCK_EN
  logic [NREQ-1:0]       lock;
`endif
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rvalid;
  logic [WIDTH-1:0]      rdata;
  logic                  bank_load;
  logic [AW-1:0]         bank_addr;
  logic [WIDTH-1:0]      bank_in;
  logic [WIDTH-1:0]      bank_out;

  logic [WIDTH-1:0] bank [2**AW];
  logic [WIDTH-1:0] mem  [2**AW];
  logic [W-1:0]     exp_q [$];

  int chk_cnt = 0;
  int err_cnt = 0;

  logic [NREQ-1:0] seq3 [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [NREQ-1:0] seq4 [4] = '{2'b10, 2'b00, 2'b10, 2'b00};
`ifdef ARB_LOCK_EN
  logic [NREQ-1:0] seq6 [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
`else
  logic [NREQ-1:0] seq6 [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

  reg_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
`ifdef ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .bank_load (bank_load),
    .bank_addr (bank_addr),
    .bank_in   (bank_in),
    .bank_out  (bank_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural bank: combinational read, write committed on the clock edge.
  assign bank_out = bank[bank_addr];
  always @(posedge clk) if (bank_load) bank[bank_addr] <= bank_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Record what each observed grant means: writes update the reference
  // memory, reads queue the expected {rvalid, rdata} for the monitor.
  task automatic note_grant();
    logic [AW-1:0]   a;
    logic [NREQ-1:0] oh;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a = addr[i*AW +: AW];
        if (we[i]) mem[a] = wdata[i*WIDTH +: WIDTH];
        else begin
          oh = '0;
          oh[i] = 1'b1;
          exp_q.push_back({oh, mem[a]});
        end
      end
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rvalid != '0) begin
      if (exp_q.size() == 0) check("rvalid_unexpected", {14'd0, rvalid, rdata}, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("read_data", {14'd0, rvalid, rdata}, {14'd0, e});
      end
    end
  end

  // Driver: one access by requester i, called just after a rising edge.
  task automatic access(input int i, input logic w, input logic [AW-1:0] a,
                        input logic [WIDTH-1:0] d);
    int n;
    logic seen;
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*AW +: AW] = a;
    wdata[i*WIDTH +: WIDTH] = d;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      seen = gnt[i];
    end
    if (!seen) check("gnt_timeout", 32'd0, 32'd1);
    else begin
      if (w) begin
        check("wr_load", {31'd0, bank_load}, 32'd1);
        check("wr_addr", {29'd0, bank_addr}, {29'd0, a});
        check("wr_in", {16'd0, bank_in}, {16'd0, d});
      end
      note_grant();
    end
    @(posedge clk);
    #1 req[i] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      bank[i] = WIDTH'(16'h1000 + i);
      mem[i]  = WIDTH'(16'h1000 + i);
    end
    reset = 1'b1;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
`ifdef ARB_LOCK_EN
    lock  = '0;
`endif

    // 1: reset with both requesting, then first grant goes to requester 0.
    req  = 2'b11;
    addr = {3'd2, 3'd1};
    repeat (3) begin
      @(negedge clk);
      check("rst_gnt", {30'd0, gnt}, 32'd0);
      check("rst_rvalid", {30'd0, rvalid}, 32'd0);
      check("rst_rdata", {16'd0, rdata}, 32'd0);
      check("rst_load", {31'd0, bank_load}, 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("first_gnt", {30'd0, gnt}, 32'h1);
    note_grant();
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(negedge clk);
    check("second_gnt", {30'd0, gnt}, 32'h2);
    note_grant();
    @(posedge clk);
    #1 req = '0;

    // 2: write then read back with latency check.
    access(0, 1'b1, 3'd3, 16'hBEEF);
    access(0, 1'b0, 3'd3, 16'h0000);
    @(negedge clk);
    check("rd_rvalid", {30'd0, rvalid}, 32'h1);
    check("rd_rdata", {16'd0, rdata}, 32'hBEEF);
    @(posedge clk);
    #1;

    // 3: both writing continuously alternate every cycle.
    do_reset();
    req   = 2'b11;
    we    = 2'b11;
    addr  = {3'd6, 3'd4};
    wdata = {16'hB0B1, 16'hA0A1};
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_both", {30'd0, gnt}, {30'd0, seq3[k]});
      note_grant();
      if (k == 3) req = '0;
    end
    @(posedge clk);
    #1 we = '0;
    access(1, 1'b0, 3'd4, 16'h0);
    access(0, 1'b0, 3'd6, 16'h0);

    // 4: sole requester held high is granted every other cycle.
    req  = 2'b10;
    addr = {3'd6, 3'd0};
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("sole_req", {30'd0, gnt}, {30'd0, seq4[k]});
      note_grant();
      if (k == 3) req = '0;
    end
    @(posedge clk);
    #1;

    // 5: reset during a write grant suppresses the write.
    req[0] = 1'b1;
    we[0]  = 1'b1;
    addr[2:0]  = 3'd5;
    wdata[15:0] = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    check("mid_gnt", {30'd0, gnt}, 32'h1);
    reset = 1'b1;
    #1 check("mid_load", {31'd0, bank_load}, 32'd0);
    @(posedge clk);
    #1 begin
      reset = 1'b0;
      req   = '0;
      we    = '0;
    end
    @(negedge clk);
    check("post_rst_gnt", {30'd0, gnt}, 32'd0);
    @(posedge clk);
    #1 access(0, 1'b0, 3'd5, 16'h0);

    // 6: lock interaction (pure round-robin without the lock port).
    do_reset();
    req  = 2'b11;
    we   = 2'b00;
    addr = {3'd2, 3'd1};
`ifdef ARB_LOCK_EN
    lock = 2'b01;
`endif
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("lock_seq", {30'd0, gnt}, {30'd0, seq6[k]});
      note_grant();
      if (k == 2) begin
        req[0] = 1'b0;
`ifdef ARB_LOCK_EN
        lock = '0;
`endif
      end
      if (k == 3) req = '0;
    end

    // Drain outstanding reads.
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    check("sb_drain", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Round-robin controller that shares one external 16-bit register bank (8 × 16-bit registers, single-port, combinational read, load-enabled write on clk) between NREQ requesters.
- Arbitrates per-requester access requests and drives the bank's load/address/data lines.
- Captures read data and returns a one-cycle rvalid pulse to the winning requester.
- Sits between requesters (CPU-side, DMA-side) and the register bank.

Parameters:
NREQ, 2, number of requesters (2..4)
WIDTH, 16, data width
AW, 3, address width; bank depth = 2**AW

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
req  input  NREQ  per-requester request, held until gnt seen
we  input  NREQ  per-requester write (1) / read (0), valid with req
addr  input  NREQ*AW  flattened addresses, requester i at [i*AW +: AW]
wdata  input  NREQ*WIDTH  flattened write data, requester i at [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, registered, one-cycle pulse
rvalid  output  NREQ  one-hot read-data-valid, cycle after read grant
rdata  output  WIDTH  registered read data, shared by all requesters
bank_load  output  1  bank write enable
bank_addr  output  AW  bank address
bank_in  output  WIDTH  bank write data
bank_out  input  WIDTH  bank combinational read data

Behaviour:
- Reset (clk edge with reset=1): gnt=0, rvalid=0, rdata=0, priority pointer=0 (requester 0 highest), state=IDLE.
- While reset=1, bank_load is forced to 0 combinationally.
- Bank contents are not reset.
- States:
  - IDLE: gnt=0.
  - GRANT: gnt one-hot = registered winner.
- Transitions, evaluated each edge:
  - Masked request = req & ~gnt.
  - If masked request != 0: winner = first set bit scanning from pointer upward, wrapping modulo NREQ. Next state is GRANT(winner) and pointer becomes (winner+1) mod NREQ.
  - Otherwise next state is IDLE and the pointer is unchanged.
- Latency:
  - req sampled at edge N; gnt high in cycle N+1.
  - Access happens in the gnt cycle.
  - Read data: rdata and rvalid are valid in cycle N+2.
- Grant cycle for requester i:
  - bank_addr = addr[i].
  - bank_in = wdata[i].
  - bank_load = we[i].
  - The bank commits the write at the end of the grant cycle.
  - If we[i]=0, rdata <= bank_out at that edge and rvalid[i]=1 for exactly one cycle.
  - rdata holds its value until the next read completes.
- Outside grant cycles: bank_load=0, bank_addr=0, bank_in=0.
- Handshake:
  - Requester holds req/we/addr/wdata stable until it samples gnt=1.
  - The grant cycle consumes the request.
  - req still high in the cycle after gnt is a new request.
  - Current grantee is masked for one arbitration, so a continuously requesting sole requester gets a grant every other cycle. Two competing requesters alternate at one access per cycle.
- Simultaneous events:
  - The write grant of one cycle followed by a read grant of the same address next cycle returns the new data, because bank writes commit before the next combinational read.
  - Write and rvalid of different requesters may coincide.
- Reset mid-operation: a pending grant is dropped; its write is not performed; a pending rvalid is cleared.
- req bits above NREQ do not exist. X on a non-requesting lane is ignored.

Optional Feature:
- Macro ARB_LOCK_EN. When defined, a port lock (input, NREQ) is added.
- If the current grantee asserts lock[i] together with req[i] in its grant cycle:
  - its grant repeats next cycle (no self-masking);
  - the pointer is frozen;
  - other requesters wait.
- Lock released when lock[i]=0 or req[i]=0; normal round-robin then resumes with pointer = (i+1) mod NREQ.
- Without the macro: no lock port and pure round-robin.

Decomposition:
- Shared package/header (include-guarded): state encoding IDLE=0, GRANT=1, default widths WIDTH=16, AW=3.
- Sub-module rr_arbiter: req, mask, pointer → one-hot winner plus next pointer, combinational.
- reg_bank_arbiter holds state, gnt, rvalid, rdata registers and the bank mux.

Test Plan:
1. Reset with req=2'b11 held → gnt=0, rvalid=0, rdata=0, bank_load=0 throughout; first grant after release goes to requester 0.
2. Req0 write addr=3 wdata=16'hBEEF, then read addr=3 → write gnt cycle shows bank_load=1, bank_addr=3; read gives rdata=16'hBEEF with rvalid=2'b01 two cycles after read req.
3. req=2'b11 held continuously (both writes) → gnt sequence 01,10,01,10 every cycle; pointer alternates.
4. Only req1 held continuously → gnt=10,00,10,00 (every other cycle).
5. Reset asserted in a write grant cycle (req0 addr=5 wdata=16'h1234) → bank_load=0, subsequent read of addr 5 returns prior value.
6. With ARB_LOCK_EN, req0 and lock0 for 3 grants while req1 high → gnt=01,01,01,10; without macro → 01,10,01,10.
